// File: rtl/mac_pkg.sv
// Shared definitions for the vector MAC: default widths, saturation bounds,
// and the product-stage register layout.
package mac_pkg;

  localparam int unsigned DEF_IN_W     = 4;
  localparam int unsigned DEF_WT_W     = 4;
  localparam int unsigned DEF_ACC_W    = 12;
  localparam int unsigned DEF_LEN_W    = 4;
  localparam bit          DEF_SATURATE = 1'b1;

  // Product field is sized for the widest supported product; users keep
  // IN_W+WT_W <= ACC_W <= S1_PROD_W.
  localparam int unsigned S1_PROD_W = 32;

  typedef struct packed {
    logic signed [S1_PROD_W-1:0] prod;
    logic                        last;
    logic                        valid;
  } s1_t;

  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational signed adder with overflow detect and optional clamping.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter bit          SATURATE = DEF_SATURATE
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    sum  = wide[ACC_W-1:0];
    if (SATURATE && ovf) begin
      sum = wide[ACC_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/mac_vec_pipe.sv
// Pipelined signed dot-product MAC: product stage, accumulate stage, and a
// held result register on a valid/ready output.
module mac_vec_pipe
  import mac_pkg::*;
#(
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned WT_W     = DEF_WT_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter bit          SATURATE = DEF_SATURATE
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic signed [WT_W-1:0]  in_weight,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf,
  output logic [LEN_W-1:0]        out_len
);

  localparam int unsigned PROD_W = IN_W + WT_W;

  s1_t                     s1;
  logic                    stall;
  logic                    accept;
  logic                    s2_fire;
  logic signed [PROD_W-1:0] prod_now;
  logic signed [S1_PROD_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] add_a;
  logic signed [ACC_W-1:0] add_b;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    ovf;
  logic                    mid_vec;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        cnt_inc;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = rstb & ~stall & ~clear;
  assign accept   = in_valid & in_ready;
  assign s2_fire  = s1.valid & ~stall;

  assign prod_now = PROD_W'(in_data) * PROD_W'(in_weight);
  assign prod_ext = S1_PROD_W'(prod_now);

  // mid_vec=0 marks the first beat of a vector, so the all-zero reset value
  // already means "start from zero".
  assign add_a   = mid_vec ? acc : '0;
  assign add_b   = $signed(s1.prod[ACC_W-1:0]);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + LEN_W'(1);

  generate
    if (ACC_W < S1_PROD_W) begin : g_prod_hi
      logic unused_prod_hi;
      assign unused_prod_hi = ^s1.prod[S1_PROD_W-1:ACC_W];
    end
  endgenerate

  mac_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1        <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      mid_vec   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_len   <= '0;
    end else if (clear) begin
      s1        <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      mid_vec   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_len   <= '0;
    end else begin
      if (!stall) begin
        s1.valid <= accept;
        if (accept) begin
          s1.prod <= prod_ext;
          s1.last <= in_last;
        end
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A consumed result and a newly completed vector can share an edge;
      // the load below then keeps out_valid high with fresh data.
      if (s2_fire) begin
        if (s1.last) begin
          out_acc   <= add_sum;
          out_ovf   <= ovf | add_ovf;
          out_len   <= cnt_inc;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf       <= 1'b0;
          cnt       <= '0;
          mid_vec   <= 1'b0;
        end else begin
          acc     <= add_sum;
          ovf     <= ovf | add_ovf;
          cnt     <= cnt_inc;
          mid_vec <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Directed bench for mac_vec_pipe: default, saturating and wrapping 8-bit
// accumulator instances share one input stream.
module tb_mac_vec_pipe;

  logic clk;
  logic rstb;
  logic clear;
  logic in_valid;
  logic in_last;
  logic out_ready;
  logic signed [3:0] in_data;
  logic signed [3:0] in_weight;

  logic ready_a, ready_s, ready_w;
  logic valid_a, valid_s, valid_w;
  logic ovf_a, ovf_s, ovf_w;
  logic signed [11:0] acc_a;
  logic signed [7:0]  acc_s, acc_w;
  logic [3:0] len_a, len_s, len_w;

  logic signed [11:0] got_acc_a;
  logic signed [7:0]  got_acc_s, got_acc_w;
  logic [3:0] got_len_a, got_len_s, got_len_w;
  logic got_ovf_a, got_ovf_s, got_ovf_w, got_valid_s, got_valid_w;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mac_vec_pipe dut_a (
    .clk(clk), .rstb(rstb), .clear(clear), .in_valid(in_valid), .in_ready(ready_a),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(valid_a), .out_ready(out_ready), .out_acc(acc_a), .out_ovf(ovf_a), .out_len(len_a)
  );

  mac_vec_pipe #(.ACC_W(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rstb(rstb), .clear(clear), .in_valid(in_valid), .in_ready(ready_s),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(valid_s), .out_ready(out_ready), .out_acc(acc_s), .out_ovf(ovf_s), .out_len(len_s)
  );

  mac_vec_pipe #(.ACC_W(8), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rstb(rstb), .clear(clear), .in_valid(in_valid), .in_ready(ready_w),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(valid_w), .out_ready(out_ready), .out_acc(acc_w), .out_ovf(ovf_w), .out_len(len_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input int d, input int w, input bit l);
    int unsigned n = 0;
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'(d);
    in_weight = 4'(w);
    in_last   = l;
    do begin
      @(negedge clk);
      ok = (ready_a === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL send_timeout: in_ready observed %b expected 1", ready_a);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Call at posedge+1; captures all outputs at the negedge where out_valid
  // is first seen, then returns at posedge+1.
  task automatic wait_result(input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while (valid_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (valid_a === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout: out_valid observed %b expected 1", tag, valid_a);
    end
    got_acc_a = acc_a; got_len_a = len_a; got_ovf_a = ovf_a;
    got_acc_s = acc_s; got_len_s = len_s; got_ovf_s = ovf_s; got_valid_s = valid_s;
    got_acc_w = acc_w; got_len_w = len_w; got_ovf_w = ovf_w; got_valid_w = valid_w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstb      = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_weight = '0;

    // Reset state
    #8;
    chk("rst_ready_a", 32'(ready_a), 0);
    chk("rst_ready_s", 32'(ready_s), 0);
    chk("rst_ready_w", 32'(ready_w), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_acc", 32'(acc_a), 0);
    chk("rst_len", 32'(len_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    #4 rstb = 1'b1;
    @(posedge clk); #1;

    // Nine-beat vector, exact latency
    send(4, 3, 0); send(-1, 2, 0); send(2, -2, 0); send(1, 1, 0); send(-3, 1, 0);
    send(3, -1, 0); send(-2, 2, 0); send(2, -3, 0); send(-4, -4, 1);
    idle();
    @(negedge clk);
    chk("v1_early_valid", 32'(valid_a), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("v1_valid", 32'(valid_a), 1);
    chk("v1_acc", 32'(acc_a), 7);
    chk("v1_len", 32'(len_a), 9);
    chk("v1_ovf", 32'(ovf_a), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("v1_consumed", 32'(valid_a), 0);
    @(posedge clk); #1;

    // Reset mid-vector discards the partial sum
    send(5, 5, 0); send(6, 6, 0);
    idle();
    #2 rstb = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_a), 0);
    chk("midrst_valid", 32'(valid_a), 0);
    #3 rstb = 1'b1;
    @(posedge clk); #1;
    send(1, 1, 0); send(-1, -1, 0); send(2, 2, 0); send(-2, -2, 0); send(3, 3, 0);
    send(-3, -3, 0); send(4, 4, 0); send(-4, -4, 0); send(1, -1, 0); send(-1, 1, 0);
    send(2, -2, 1);
    idle();
    wait_result("v2");
    chk("v2_acc", 32'(got_acc_a), 54);
    chk("v2_len", 32'(got_len_a), 11);
    chk("v2_ovf", 32'(got_ovf_a), 0);

    // Overflow: three 64 products
    send(-8, -8, 0); send(-8, -8, 0); send(-8, -8, 1);
    idle();
    wait_result("v3");
    chk("v3_acc_wide", 32'(got_acc_a), 192);
    chk("v3_ovf_wide", 32'(got_ovf_a), 0);
    chk("v3_valid_sat", 32'(got_valid_s), 1);
    chk("v3_acc_sat", 32'(got_acc_s), 127);
    chk("v3_ovf_sat", 32'(got_ovf_s), 1);
    chk("v3_len_sat", 32'(got_len_s), 3);
    chk("v3_valid_wrap", 32'(got_valid_w), 1);
    chk("v3_acc_wrap", 32'(got_acc_w), -64);
    chk("v3_ovf_wrap", 32'(got_ovf_w), 1);
    chk("v3_len_wrap", 32'(got_len_w), 3);

    // Backpressure hold with a beat already in the product stage
    out_ready = 1'b0;
    send(2, 2, 0); send(1, 3, 1);
    in_valid = 1'b1; in_data = 4'sd3; in_weight = 4'sd1; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 4'sd4;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(valid_a), 1);
      chk("hold_acc", 32'(acc_a), 7);
      chk("hold_len", 32'(len_a), 2);
      chk("hold_ready", 32'(ready_a), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4, 1, 0); send(5, 1, 1);
    idle();
    wait_result("v4");
    chk("v4_acc", 32'(got_acc_a), 12);
    chk("v4_len", 32'(got_len_a), 3);

    // Single-beat vectors back to back
    in_valid = 1'b1; in_last = 1'b1; in_data = 4'sd1; in_weight = 4'sd1;
    @(posedge clk); #1;
    in_data = 4'sd2; in_weight = 4'sd2;
    @(negedge clk);
    chk("b2b_pre_valid", 32'(valid_a), 0);
    @(posedge clk); #1;
    in_data = 4'sd3; in_weight = 4'sd3;
    @(negedge clk);
    chk("b2b_r1_valid", 32'(valid_a), 1);
    chk("b2b_r1_acc", 32'(acc_a), 1);
    chk("b2b_r1_len", 32'(len_a), 1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("b2b_r2_valid", 32'(valid_a), 1);
    chk("b2b_r2_acc", 32'(acc_a), 4);
    chk("b2b_r2_len", 32'(len_a), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_r3_valid", 32'(valid_a), 1);
    chk("b2b_r3_acc", 32'(acc_a), 9);
    chk("b2b_r3_len", 32'(len_a), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_drained", 32'(valid_a), 0);
    @(posedge clk); #1;

    // Clear with a pending result and a beat in flight
    out_ready = 1'b0;
    send(1, 1, 1); send(2, 2, 0);
    idle();
    @(negedge clk);
    chk("clr_pending_valid", 32'(valid_a), 1);
    chk("clr_pending_acc", 32'(acc_a), 1);
    @(posedge clk); #1;
    clear = 1'b1;
    in_valid = 1'b1; in_data = 4'sd7; in_weight = 4'sd7; in_last = 1'b1;
    @(negedge clk);
    chk("clr_ready", 32'(ready_a), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("clr_valid", 32'(valid_a), 0);
    chk("clr_acc", 32'(acc_a), 0);
    chk("clr_len", 32'(len_a), 0);
    @(posedge clk); #1;
    send(2, 3, 1);
    idle();
    wait_result("v6");
    chk("v6_acc", 32'(got_acc_a), 6);
    chk("v6_len", 32'(got_len_a), 1);
    chk("v6_ovf", 32'(got_ovf_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
